ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the opposite direction of the existing `ps2` keyboard receiver.
- Sends one command byte to the keyboard per request, e.g. 8'hED set-LEDs, 8'hFF reset, 8'hF4 enable.
- Runs on the 100 MHz system clk and drives the PS/2 lines open-drain.
- Sits beside `ps2` in the top level. It raises rx_inhibit so the receiver ignores the clock edges it generates during a host transfer.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles the host holds PS2Clk low before requesting to send (120 us).
- START_TIMEOUT, 1500000: max cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 200000: max cycles from the first device falling edge to line idle after ACK (2 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready
- ps2_clk_in  in  1  raw PS2Clk pad value
- ps2_data_in  in  1  raw PS2Data pad value
- ps2_clk_oe  out  1  1 = pull PS2Clk low, 0 = release
- ps2_data_oe  out  1  1 = pull PS2Data low, 0 = release
- rx_inhibit  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse at end of every accepted transfer
- ack_ok  out  1  valid with done; device ACKed
- err_timeout  out  1  valid with done; a timeout occurred
- err_noack  out  1  valid with done; ACK bit sampled high

Behaviour:
- Clock and reset:
  - Single clock domain. rst_n is asynchronous, active-low.
  - While rst_n is low, every output is 0 except tx_ready, which is 1. The FSM is in IDLE and both lines are released, including when reset is asserted mid-transfer.
- Input sync:
  - Both lines pass through 2-FF synchronizers.
  - fall = previous synced clk 1 and current 0; one-cycle pulse, 2-3 cycles after the pad edge.
- Accept:
  - In IDLE, tx_valid && tx_ready latches shift = {1'b1 stop, ~^tx_data odd parity, tx_data}, LSB at shift[0].
  - Next state INHIBIT; ps2_clk_oe = 1 from the following cycle.
  - tx_valid while not IDLE is ignored; nothing is queued.
- INHIBIT:
  - Counter runs 0..INHIBIT_CYCLES-1 with clk_oe = 1.
  - In the final cycle data_oe is set to 1 (start bit), so data goes low while clock is still low.
  - Next state REQ: clk_oe = 0, data_oe held 1, timer cleared.
- REQ:
  - Wait for fall. On fall: data_oe <= ~shift[0], shift >>= 1, bitcnt = 1, timer cleared, go to BITS.
  - If the timer reaches START_TIMEOUT first, go to FAIL with the timeout flag.
- BITS:
  - Each fall drives the next bit: data_oe <= ~shift[0], bitcnt++.
  - Bits go out on falls 1..10 in order d0..d7, parity, stop. Fall 10 releases data (stop = 1).
  - After fall 10, go to ACK.
- ACK:
  - On fall 11, sample synced data: 0 = ack, 1 = noack. Go to IDLE_WAIT.
- IDLE_WAIT:
  - Wait until synced clk and data are both 1, then go to DONE.
- Transfer timeout:
  - BITS, ACK and IDLE_WAIT share one timer started at fall 1.
  - Timer reaching XFER_TIMEOUT goes to FAIL with the timeout flag.
- DONE / FAIL:
  - One cycle: both oe = 0, done = 1, flags presented.
  - ack_ok = ack && !timeout. err_noack = !ack && !timeout. err_timeout = timeout.
  - Exactly one flag is high. Then IDLE; tx_ready = 1 on the next cycle.
- Line discipline:
  - oe signals are registered outputs.
  - clk_oe is never 1 outside INHIBIT.
  - data_oe is never 1 in ACK, IDLE_WAIT, DONE or FAIL.
- Timer width:
  - Counter is 21 bits, enough for START_TIMEOUT. It saturates and never wraps.

Decomposition:
- Shared package ps2_pkg holds:
  - State enum: IDLE, INHIBIT, REQ, BITS, ACK, IDLE_WAIT, DONE, FAIL.
  - Command constants: CMD_SET_LEDS 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF.
  - Reply constants: RSP_ACK 8'hFA, RSP_RESEND 8'hFE.
  - Arrow key codes 8'h6B, 8'h72, 8'h74, 8'h75.
- One sub-module, ps2_line_sync: 2-FF sync of clk/data plus the fall pulse. It is reusable by the receiver.

Test Plan:
Bench uses INHIBIT_CYCLES = 20, START_TIMEOUT = 500, XFER_TIMEOUT = 2000. A device model generates a 40-cycle PS/2 clock period.
- Send 8'hED, device ACKs -> clk_oe high for exactly 20 cycles; data_oe high on the last of them. Bits sampled at device rising edges are 0,1,0,1,1,0,1,1,1,1,1 (start, d0..d7, parity = 1, stop). done pulses once with ack_ok = 1.
- Send 8'h00 -> parity bit 1, stop bit 1; ack_ok = 1.
- Send 8'hFF, device never clocks -> exactly 500 cycles after clock release, done and err_timeout = 1. Both oe = 0; tx_ready = 1 the next cycle.
- Send 8'hF4, device leaves data high on fall 11 -> done with err_noack = 1, ack_ok = 0.
- rst_n low during bit 4 -> clk_oe and data_oe go to 0 asynchronously, no done pulse. After release, a new 8'hED transfer completes with ack_ok = 1.
- tx_valid held high with 8'h11 during a busy transfer -> not accepted, tx_ready = 0 throughout. After done, the held request is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, keyboard command/reply bytes
// and scan codes used by both the receiver and the host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    IDLE_WAIT,
    DONE,
    FAIL
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;

  localparam int TIMER_W = 21;

  // PS/2 frames carry odd parity over the data byte
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a one-cycle
// pulse on each synchronized falling edge of PS2Clk.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Idle PS/2 lines are pulled high, so the synchronizers reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte per request and
// reports ACK, no-ACK or timeout through a one-cycle done pulse.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout,
  output logic       err_noack
);

  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] INH_START  = TIMER_W'(INHIBIT_CYCLES - 2);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_TIMEOUT - 1);

  tx_state_t          state, state_n;
  logic [9:0]         shift_q, shift_n;
  logic [3:0]         bit_cnt_q, bit_cnt_n;
  logic [TIMER_W-1:0] timer_q, timer_n, timer_inc;
  logic               clk_oe_q, clk_oe_n;
  logic               data_oe_q, data_oe_n;
  logic               ack_q, ack_n;
  logic               clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk_in),
    .ps2_data (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  // Saturating so a stuck line can never wrap the timer back under a limit
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_n;
      shift_q   <= shift_n;
      bit_cnt_q <= bit_cnt_n;
      timer_q   <= timer_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      ack_q     <= ack_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    bit_cnt_n = bit_cnt_q;
    timer_n   = timer_inc;
    clk_oe_n  = clk_oe_q;
    data_oe_n = data_oe_q;
    ack_n     = ack_q;

    case (state)
      IDLE: begin
        timer_n   = '0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          shift_n   = {1'b1, odd_parity(tx_data), tx_data};
          bit_cnt_n = '0;
          ack_n     = 1'b0;
          clk_oe_n  = 1'b1;
          data_oe_n = (INHIBIT_CYCLES == 1);
          state_n   = INHIBIT;
        end
      end

      // Start bit goes low in the last inhibit cycle, while clock is still held
      INHIBIT: begin
        if (timer_q == INH_START) data_oe_n = 1'b1;
        if (timer_q >= INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          timer_n   = '0;
          state_n   = REQ;
        end
      end

      REQ: begin
        if (clk_fall) begin
          data_oe_n = ~shift_q[0];
          shift_n   = {1'b0, shift_q[9:1]};
          bit_cnt_n = 4'd1;
          timer_n   = '0;
          state_n   = BITS;
        end else if (timer_q >= START_LAST) begin
          data_oe_n = 1'b0;
          state_n   = FAIL;
        end
      end

      BITS: begin
        if (timer_q >= XFER_LAST) begin
          data_oe_n = 1'b0;
          state_n   = FAIL;
        end else if (clk_fall) begin
          data_oe_n = ~shift_q[0];
          shift_n   = {1'b0, shift_q[9:1]};
          bit_cnt_n = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_n = ACK;
        end
      end

      ACK: begin
        if (timer_q >= XFER_LAST) begin
          state_n = FAIL;
        end else if (clk_fall) begin
          ack_n   = ~data_s;
          state_n = IDLE_WAIT;
        end
      end

      IDLE_WAIT: begin
        if (timer_q >= XFER_LAST) state_n = FAIL;
        else if (clk_s && data_s) state_n = DONE;
      end

      DONE, FAIL: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state == IDLE);
  assign rx_inhibit  = (state != IDLE);
  assign done        = (state == DONE) || (state == FAIL);
  assign ack_ok      = (state == DONE) && ack_q;
  assign err_noack   = (state == DONE) && !ack_q;
  assign err_timeout = (state == FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// every frame is compared with one built from the byte by plain arithmetic.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 500;
  localparam int XTO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit;
  logic       done, ack_ok, err_timeout, err_noack;
  logic       ps2_clk_line, ps2_data_line;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         clk_oe_cnt;
    int         both_cnt;
    bit         data_last;
    int         done_cnt;
    logic [2:0] flags;
    int         rel_idx;
    int         done_idx;
    bit         oe_at_done;
    int         ready_busy;
    bit         ready_after;
    bit         expired;
  } mon_t;

  // Open-drain wiring: either side may pull a line low
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .ack_ok      (ack_ok),
    .err_timeout (err_timeout),
    .err_noack   (err_noack)
  );

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // mode 0: ACK, mode 1: never clocks, mode 2: no ACK
  task automatic device_run(input int mode, output logic [10:0] got, output bit found);
    int n;
    got = '0;
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    found = (n < 200);
    got[0] = ps2_data_line;
    if (!found || mode == 1) return;
    for (int i = 1; i <= 11; i++) begin
      if (i == 11 && mode == 0) begin
        repeat (10) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) got[i] = ps2_data_line;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic host_monitor(input int limit, output mon_t r);
    bit prev_clk, prev_data, seen;
    int k;
    r = '{default: 0};
    r.rel_idx = -1;
    prev_clk = 1'b0;
    prev_data = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < limit) begin
      if (ps2_clk_oe) r.clk_oe_cnt++;
      if (ps2_clk_oe && ps2_data_oe) r.both_cnt++;
      if (prev_clk && !ps2_clk_oe) begin
        r.data_last = prev_data;
        r.rel_idx = k;
      end
      if (tx_ready) r.ready_busy++;
      if (done) begin
        seen = 1'b1;
        r.done_cnt++;
        r.flags = {ack_ok, err_timeout, err_noack};
        r.done_idx = k;
        r.oe_at_done = ps2_clk_oe | ps2_data_oe;
      end
      prev_clk = ps2_clk_oe;
      prev_data = ps2_data_oe;
      @(negedge clk);
      k++;
    end
    r.expired = !seen;
    if (seen) begin
      r.ready_after = tx_ready;
      if (done) r.done_cnt++;
    end
  endtask

  task automatic run_transfer(input logic [7:0] b, input int mode, input bit hold,
                              input logic [7:0] next_b, output logic [10:0] got,
                              output bit found, output mon_t m);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = hold;
    if (hold) tx_data = next_b;
    fork
      device_run(mode, got, found);
      host_monitor(4000, m);
    join
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, err_timeout, err_noack} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000",
               {ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, err_timeout, err_noack});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_leds();
    logic [10:0] got;
    bit found;
    mon_t m;
    run_transfer(8'hED, 0, 1'b0, 8'h00, got, found, m);
    checks++;
    if (!found || m.expired) begin
      errors++;
      $display("[TB] FAIL leds_handshake: got found=%b expired=%b expected found=1 expired=0", found, m.expired);
    end
    checks++;
    if (got !== 11'b111_1101_1010) begin
      errors++;
      $display("[TB] FAIL leds_bits: got %b expected 11111011010", got);
    end
    checks++;
    if (got !== frame_of(8'hED)) begin
      errors++;
      $display("[TB] FAIL leds_model: got %b expected %b", got, frame_of(8'hED));
    end
    checks++;
    if (m.clk_oe_cnt != INH || m.both_cnt != 1 || m.data_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL leds_inhibit: got clk_oe=%0d both=%0d last=%b expected %0d 1 1",
               m.clk_oe_cnt, m.both_cnt, m.data_last, INH);
    end
    checks++;
    if (m.done_cnt != 1 || m.flags !== 3'b100 || m.oe_at_done) begin
      errors++;
      $display("[TB] FAIL leds_done: got cnt=%0d flags=%b oe=%b expected 1 100 0",
               m.done_cnt, m.flags, m.oe_at_done);
    end
  endtask

  task automatic test_send_zero();
    logic [10:0] got;
    bit found;
    mon_t m;
    run_transfer(8'h00, 0, 1'b0, 8'h00, got, found, m);
    checks++;
    if (got !== frame_of(8'h00) || got[10:9] !== 2'b11) begin
      errors++;
      $display("[TB] FAIL zero_bits: got %b expected %b", got, frame_of(8'h00));
    end
    checks++;
    if (m.done_cnt != 1 || m.flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL zero_done: got cnt=%0d flags=%b expected 1 100", m.done_cnt, m.flags);
    end
  endtask

  task automatic test_start_timeout();
    logic [10:0] got;
    bit found;
    mon_t m;
    run_transfer(8'hFF, 1, 1'b0, 8'h00, got, found, m);
    checks++;
    if (!found || m.expired || m.done_idx - m.rel_idx != STO) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expired=%b expected %0d",
               m.done_idx - m.rel_idx, m.expired, STO);
    end
    checks++;
    if (m.flags !== 3'b010 || m.oe_at_done || m.ready_after !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_done: got flags=%b oe=%b ready=%b expected 010 0 1",
               m.flags, m.oe_at_done, m.ready_after);
    end
  endtask

  task automatic test_noack();
    logic [10:0] got;
    bit found;
    mon_t m;
    run_transfer(8'hF4, 2, 1'b0, 8'h00, got, found, m);
    checks++;
    if (got !== frame_of(8'hF4)) begin
      errors++;
      $display("[TB] FAIL noack_bits: got %b expected %b", got, frame_of(8'hF4));
    end
    checks++;
    if (m.done_cnt != 1 || m.flags !== 3'b001) begin
      errors++;
      $display("[TB] FAIL noack_done: got cnt=%0d flags=%b expected 1 001", m.done_cnt, m.flags);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    bit found;
    mon_t m;
    int n, dones;
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i <= 5; i++) begin
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      if (i < 5) begin
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_bit4: got data_oe=%b expected 1", ps2_data_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, done, tx_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL rstmid_async: got %b expected 0001",
               {ps2_clk_oe, ps2_data_oe, done, tx_ready});
    end
    dev_clk_low = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 10) rst_n = 1'b1;
      if (done || ps2_clk_oe || ps2_data_oe) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_quiet: got %0d active cycles expected 0", dones);
    end
    run_transfer(8'hED, 0, 1'b0, 8'h00, got, found, m);
    checks++;
    if (got !== frame_of(8'hED) || m.done_cnt != 1 || m.flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL rstmid_retry: got bits=%b flags=%b cnt=%0d expected %b 100 1",
               got, m.flags, m.done_cnt, frame_of(8'hED));
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got;
    bit found;
    mon_t m;
    run_transfer(8'hED, 0, 1'b1, 8'h11, got, found, m);
    checks++;
    if (got !== frame_of(8'hED) || m.ready_busy != 0 || m.flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL b2b_first: got bits=%b ready_busy=%0d flags=%b expected %b 0 100",
               got, m.ready_busy, m.flags, frame_of(8'hED));
    end
    checks++;
    if (m.ready_after !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got ready=%b expected 1", m.ready_after);
    end
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, tx_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got clk_oe,ready=%b expected 10", {ps2_clk_oe, tx_ready});
    end
    tx_valid = 1'b0;
    fork
      device_run(0, got, found);
      host_monitor(4000, m);
    join
    checks++;
    if (got !== frame_of(8'h11) || m.done_cnt != 1 || m.flags !== 3'b100) begin
      errors++;
      $display("[TB] FAIL b2b_second: got bits=%b flags=%b cnt=%0d expected %b 100 1",
               got, m.flags, m.done_cnt, frame_of(8'h11));
    end
  endtask

  task automatic test_random();
    logic [10:0] got;
    bit found;
    mon_t m;
    logic [7:0] b;
    int mode;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      run_transfer(b, mode, 1'b0, 8'h00, got, found, m);
      checks++;
      if (got !== frame_of(b) || m.done_cnt != 1 ||
          m.flags !== ((mode == 0) ? 3'b100 : 3'b001)) begin
        errors++;
        $display("[TB] FAIL random_%0d: got byte=%h bits=%b flags=%b expected %b mode=%0d",
                 i, b, got, m.flags, frame_of(b), mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_send_leds();
    test_send_zero();
    test_start_timeout();
    test_noack();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
